// File: rtl/boot_pkg.sv
// Shared types and constants for the boot-time memory sequencer.
// Optional checksum build: define BOOT_CHECKSUM_EN.
package boot_pkg;

    localparam int WORD_W   = 32;
    localparam int BYTE_OFF = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR_D,
        LOAD_I,
        RELEASE,
        RUN,
        ERROR
    } boot_state_t;

    typedef struct packed {
        logic cpu_reset;
        logic busy;
        logic done;
        logic ld_ready;
    } boot_flags_t;

    // Registered status bits that go with each state.
    function automatic boot_flags_t state_flags(boot_state_t s);
        boot_flags_t f;
        f = '{cpu_reset: 1'b1, busy: 1'b0,
              done: 1'b0, ld_ready: 1'b0};
        unique case (s)
            CLEAR_D: f.busy = 1'b1;
            LOAD_I: begin
                f.busy     = 1'b1;
                f.ld_ready = 1'b1;
            end
            RELEASE: f.busy = 1'b1;
            RUN: begin
                f.cpu_reset = 1'b0;
                f.done      = 1'b1;
            end
            default: ;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/boot_port_mux.sv
// Data-memory write port select: sequencer clear path or CPU
// pass-through once the core is running.
module boot_port_mux
    import boot_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              run,
    input  logic              seq_write,
    input  logic [ADDR_W-1:0] seq_addr,
    input  logic [WORD_W-1:0] seq_wdata,
    input  logic              cpu_d_write,
    input  logic [ADDR_W-1:0] cpu_d_addr,
    input  logic [WORD_W-1:0] cpu_d_wdata,
    output logic              d_mem_write,
    output logic [ADDR_W-1:0] d_mem_addr,
    output logic [WORD_W-1:0] d_mem_wdata
);

    always_comb begin
        d_mem_write = seq_write;
        d_mem_addr  = seq_addr;
        d_mem_wdata = seq_wdata;
        unique case (1'b1)
            run: begin
                d_mem_write = cpu_d_write;
                d_mem_addr  = cpu_d_addr;
                d_mem_wdata = cpu_d_wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/boot_mem_sequencer.sv
// Boot controller: clears data memory, streams in instruction memory,
// then releases the CPU. Optional checksum build: BOOT_CHECKSUM_EN.
module boot_mem_sequencer
    import boot_pkg::*;
#(
    parameter int D_WORDS = 256,
    parameter int I_WORDS = 64,
    parameter int ADDR_W  = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     ld_valid,
    input  logic [WORD_W-1:0]        ld_data,
    input  logic                     ld_last,
`ifdef BOOT_CHECKSUM_EN
    input  logic [WORD_W-1:0]        ld_checksum,
    output logic                     cksum_err,
`endif
    output logic                     ld_ready,
    input  logic                     cpu_d_write,
    input  logic [ADDR_W-1:0]        cpu_d_addr,
    input  logic [WORD_W-1:0]        cpu_d_wdata,
    output logic                     d_mem_write,
    output logic [ADDR_W-1:0]        d_mem_addr,
    output logic [WORD_W-1:0]        d_mem_wdata,
    output logic                     i_mem_write,
    output logic [ADDR_W-1:0]        i_mem_addr,
    output logic [WORD_W-1:0]        i_mem_wdata,
    output logic                     cpu_reset,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(I_WORDS):0] words_loaded
);

    localparam int CNT_MAX =
        (D_WORDS > I_WORDS) ? D_WORDS : I_WORDS;
    localparam int CW   = $clog2(CNT_MAX);
    localparam int WL_W = $clog2(I_WORDS) + 1;

    localparam logic [CW-1:0] D_LAST = CW'(D_WORDS - 1);
    localparam logic [CW-1:0] I_LAST = CW'(I_WORDS - 1);

    boot_state_t state;
    boot_flags_t flags;
    logic [CW-1:0] cnt;

    logic beat;
    logic last_beat;
    logic clear_wr;
    logic run_sel;
    logic [ADDR_W-1:0] cnt_addr;

`ifdef BOOT_CHECKSUM_EN
    logic [WORD_W-1:0] sum;
`endif

    function automatic logic [ADDR_W-1:0] addr_of(
        input logic [CW-1:0] c
    );
        return ADDR_W'(c) << BYTE_OFF;
    endfunction

    // Reset gates every write strobe so an abort never leaks a write.
    assign beat      = flags.ld_ready & ld_valid & ~reset;
    assign last_beat = ld_last | (cnt == I_LAST);
    assign clear_wr  = (state == CLEAR_D) & ~reset;
    assign run_sel   = (state == RUN) & ~reset;
    assign cnt_addr  = addr_of(cnt);

    assign cpu_reset = flags.cpu_reset;
    assign busy      = flags.busy;
    assign done      = flags.done;
    assign ld_ready  = flags.ld_ready;

    assign i_mem_write = beat;
    assign i_mem_addr  = beat ? cnt_addr : '0;
    assign i_mem_wdata = beat ? ld_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            flags        <= state_flags(IDLE);
            cnt          <= '0;
            words_loaded <= '0;
`ifdef BOOT_CHECKSUM_EN
            sum          <= '0;
            cksum_err    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state        <= CLEAR_D;
                        flags        <= state_flags(CLEAR_D);
                        cnt          <= '0;
                        words_loaded <= '0;
`ifdef BOOT_CHECKSUM_EN
                        sum          <= '0;
`endif
                    end
                end
                CLEAR_D: begin
                    if (cnt == D_LAST) begin
                        state <= LOAD_I;
                        flags <= state_flags(LOAD_I);
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                LOAD_I: begin
                    if (beat) begin
                        cnt          <= cnt + CW'(1);
                        words_loaded <= words_loaded + WL_W'(1);
`ifdef BOOT_CHECKSUM_EN
                        sum          <= sum + ld_data;
`endif
                        if (last_beat) begin
                            state <= RELEASE;
                            flags <= state_flags(RELEASE);
                        end
                    end
                end
                RELEASE: begin
`ifdef BOOT_CHECKSUM_EN
                    if (sum != ld_checksum) begin
                        state     <= ERROR;
                        flags     <= state_flags(ERROR);
                        cksum_err <= 1'b1;
                    end else begin
                        state <= RUN;
                        flags <= state_flags(RUN);
                    end
`else
                    state <= RUN;
                    flags <= state_flags(RUN);
`endif
                end
                RUN: ;
`ifdef BOOT_CHECKSUM_EN
                ERROR: ;
`endif
                default: begin
                    state <= IDLE;
                    flags <= state_flags(IDLE);
                end
            endcase
        end
    end

    boot_port_mux #(
        .ADDR_W(ADDR_W)
    ) u_port_mux (
        .run         (run_sel),
        .seq_write   (clear_wr),
        .seq_addr    (clear_wr ? cnt_addr : '0),
        .seq_wdata   ('0),
        .cpu_d_write (cpu_d_write),
        .cpu_d_addr  (cpu_d_addr),
        .cpu_d_wdata (cpu_d_wdata),
        .d_mem_write (d_mem_write),
        .d_mem_addr  (d_mem_addr),
        .d_mem_wdata (d_mem_wdata)
    );

endmodule

// File: tb/tb_boot_mem_sequencer.sv
// Directed bench for boot_mem_sequencer (default parameters).
// Define BOOT_CHECKSUM_EN to also exercise the checksum path.
module tb_boot_mem_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        cpu_d_write = 1'b0;
    logic [9:0]  cpu_d_addr = '0;
    logic [31:0] cpu_d_wdata = '0;
    logic        d_mem_write;
    logic [9:0]  d_mem_addr;
    logic [31:0] d_mem_wdata;
    logic        i_mem_write;
    logic [9:0]  i_mem_addr;
    logic [31:0] i_mem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic [6:0]  words_loaded;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0] ld_checksum = '0;
    logic        cksum_err;
`endif

    int n_checks = 0;
    int n_pass = 0;

    boot_mem_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
`ifdef BOOT_CHECKSUM_EN
        .ld_checksum  (ld_checksum),
        .cksum_err    (cksum_err),
`endif
        .ld_ready     (ld_ready),
        .cpu_d_write  (cpu_d_write),
        .cpu_d_addr   (cpu_d_addr),
        .cpu_d_wdata  (cpu_d_wdata),
        .d_mem_write  (d_mem_write),
        .d_mem_addr   (d_mem_addr),
        .d_mem_wdata  (d_mem_wdata),
        .i_mem_write  (i_mem_write),
        .i_mem_addr   (i_mem_addr),
        .i_mem_wdata  (i_mem_wdata),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h",
                      tag, got, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic start_clear();
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (256) cycle();
    endtask

    logic [31:0] prog [4] = '{32'h0000_0093, 32'h0010_0113,
                              32'h0020_81B3, 32'h0000_006F};

    int       ok;
    int       writes;
    int       gap_wr;
    logic [9:0] last_addr;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // reset state
        cycle();
        settle();
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_words", words_loaded, 0);
        check("rst_ready", ld_ready, 0);
        check("rst_dwr", {d_mem_write, d_mem_addr}, 0);
        check("rst_iwr", {i_mem_write, i_mem_addr}, 0);
        cycle();
        reset = 1'b0;

        // clear phase
        start = 1'b1;
        settle();
        check("idle_no_write", d_mem_write, 0);
        cycle();
        start = 1'b0;
        ok = 0;
        for (int i = 0; i < 256; i++) begin
            settle();
            if (d_mem_write && d_mem_addr == 10'(i * 4) &&
                d_mem_wdata == 0 && busy && !ld_ready)
                ok++;
            last_addr = d_mem_addr;
            cycle();
        end
        check("clr_cycles", ok, 256);
        check("clr_last_addr", last_addr, 10'h3FC);
        settle();
        check("clr_end_write", d_mem_write, 0);
        check("ld_ready_rise", ld_ready, 1);

        // short program load
        for (int k = 0; k < 4; k++) begin
            ld_valid = 1'b1;
            ld_data = prog[k];
            ld_last = (k == 3);
            settle();
            check("ld_addr", i_mem_addr, k * 4);
            check("ld_wr", {i_mem_write, i_mem_wdata},
                  {1'b1, prog[k]});
            cycle();
        end
        ld_valid = 1'b0;
        ld_last = 1'b0;
        settle();
        check("rel_words", words_loaded, 4);
        check("rel_cpu_reset", cpu_reset, 1);
        check("rel_busy", busy, 1);
        check("rel_ready", ld_ready, 0);
        cycle();
        settle();
        check("run_cpu_reset", cpu_reset, 0);
        check("run_done", done, 1);

        // pass-through and ignored start
        cpu_d_write = 1'b1;
        cpu_d_addr = 10'h010;
        cpu_d_wdata = 32'hDEAD_BEEF;
        settle();
        check("pt_write", d_mem_write, 1);
        check("pt_addr", d_mem_addr, 10'h010);
        check("pt_data", d_mem_wdata, 32'hDEAD_BEEF);
        cycle();
        cpu_d_write = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        settle();
        check("run_start_done", done, 1);
        check("run_start_busy", busy, 0);
        check("run_start_dwr", d_mem_write, 0);
        check("run_words_hold", words_loaded, 4);

        // stalls then overflow past I_WORDS
        do_reset();
        start_clear();
        ok = 0;
        writes = 0;
        gap_wr = 0;
        for (int j = 0; j < 70; j++) begin
            if (j == 2 || j == 5 || j == 6) begin
                ld_valid = 1'b0;
                ld_data = 32'hFFFF_FFFF;
                settle();
                if (i_mem_write) gap_wr++;
                cycle();
            end
            ld_valid = 1'b1;
            ld_data = 32'hA000_0000 + j;
            settle();
            if (i_mem_write) begin
                if (i_mem_addr == 10'(writes * 4) &&
                    i_mem_wdata == ld_data)
                    ok++;
                writes++;
                last_addr = i_mem_addr;
            end
            cycle();
        end
        settle();
        check("ovf_ready", ld_ready, 0);
        check("ovf_no_write", i_mem_write, 0);
        ld_valid = 1'b0;
        check("ovf_writes", writes, 64);
        check("ovf_addr_ok", ok, 64);
        check("ovf_last_addr", last_addr, 10'h0FC);
        check("gap_writes", gap_wr, 0);
        check("ovf_words", words_loaded, 64);
        check("ovf_done", done, 1);

        // reset in the middle of clearing
        do_reset();
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (100) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        settle();
        check("mid_cpu_reset", cpu_reset, 1);
        check("mid_busy", busy, 0);
        check("mid_dwr", d_mem_write, 0);
        check("mid_ready", ld_ready, 0);
        cycle();
        settle();
        check("mid_idle_dwr", d_mem_write, 0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        settle();
        check("restart_dwr", d_mem_write, 1);
        check("restart_addr0", d_mem_addr, 0);
        cycle();
        settle();
        check("restart_addr1", d_mem_addr, 4);

`ifdef BOOT_CHECKSUM_EN
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            ld_checksum = (pass == 0) ? 32'd7 : 32'd6;
            start_clear();
            for (int k = 0; k < 3; k++) begin
                ld_valid = 1'b1;
                ld_data = k + 1;
                ld_last = (k == 2);
                cycle();
            end
            ld_valid = 1'b0;
            ld_last = 1'b0;
            cycle();
            settle();
            if (pass == 0) begin
                check("ck_bad_err", cksum_err, 1);
                check("ck_bad_cpu_reset", cpu_reset, 1);
                check("ck_bad_done", done, 0);
                check("ck_bad_busy", busy, 0);
            end else begin
                check("ck_ok_err", cksum_err, 0);
                check("ck_ok_cpu_reset", cpu_reset, 0);
                check("ck_ok_done", done, 1);
            end
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
